// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide sequencer for the Execute stage.
//
// Owns the HI/LO architectural registers. A MULT/MULTU/DIV/DIVU accepted on
// `start` is computed at the accepting edge into pending registers and
// committed to HI/LO after a fixed latency (MUL_CYCLES / DIV_CYCLES). During
// that time `busy` is high. MTHI/MTLO write HI/LO directly from IDLE. The
// MFHI/MFLO read path is combinational through `dataRead`.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   accept `operation` this cycle (ignored while busy)
//   operation in   4-bit opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                  5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 treated as NONE
//   operand1  in   rs value (dividend / multiplicand / MTHI-MTLO source)
//   operand2  in   rt value (divisor / multiplier)
//   cancel    in   exception flush; aborts an in-flight op, blocks a start
//   busy      out  high while an op is in flight
//   done      out  one-cycle pulse at HI/LO commit
//   hi, lo    out  architectural HI/LO
//   dataRead  out  hi for MFHI, lo for MFLO, else 0 (combinational)
module mdu_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  operation,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] dataRead
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    localparam logic [4:0] MulLoad = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DivLoad = 5'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    // Arithmetic datapath, evaluated from the live operands every cycle.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic        div_signed;
    logic [31:0] quot, rem;

    always_comb begin
        // Sign-extending to 64 bits lets one 64x64 multiplier (low half) serve
        // both the signed and unsigned forms.
        mul_signed = (operation == OpMult);
        mul_a      = {{32{mul_signed & operand1[31]}}, operand1};
        mul_b      = {{32{mul_signed & operand2[31]}}, operand2};
        prod       = mul_a * mul_b;
    end

    always_comb begin
        div_signed = (operation == OpDiv);
        quot       = '0;
        rem        = '0;
        if (operand2 == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = operand1;
        end else if (div_signed && operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end else if (div_signed) begin
            // SV signed / truncates toward zero; % takes the dividend's sign.
            quot = $unsigned($signed(operand1) / $signed(operand2));
            rem  = $unsigned($signed(operand1) % $signed(operand2));
        end else begin
            quot = operand1 / operand2;
            rem  = operand1 % operand2;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        unique case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    case (operation)
                        OpMult, OpMultu: begin
                            pend_hi_d = prod[63:32];
                            pend_lo_d = prod[31:0];
                            cnt_d     = MulLoad;
                            busy_d    = 1'b1;
                            state_d   = StRun;
                        end
                        OpDiv, OpDivu: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            cnt_d     = DivLoad;
                            busy_d    = 1'b1;
                            state_d   = StRun;
                        end
                        OpMthi:  hi_d = operand1;
                        OpMtlo:  lo_d = operand1;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Cancel takes priority over a same-cycle commit.
                if (cancel) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        dataRead = '0;
        if (operation == OpMfhi) begin
            dataRead = hi_q;
        end else if (operation == OpMflo) begin
            dataRead = lo_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller feeding the Execute stage. It owns the HI/LO architectural registers and accepts one operation per `start`.
- It models fixed MULT/DIV latencies and drives `busy`; EX ORs `busy` into its stall whenever the current instruction uses the MDU.
- It returns HI/LO reads on `dataRead` combinationally, so mfhi/mflo resolve in EX without an extra cycle.

Parameters:
- MUL_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO commit (legal range 1..31)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO commit (legal range 1..31)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  accept `operation` this cycle; EX gates it with its own stall
- operation  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 reserved, treated as NONE
- operand1  in  32  rs value (dividend / multiplicand / MTHI-MTLO source)
- operand2  in  32  rt value (divisor / multiplier)
- cancel  in  1  exception flush; aborts an in-flight op
- busy  out  1  registered; high while an op is in flight
- done  out  1  registered one-cycle pulse at HI/LO commit
- hi  out  32  current HI register
- lo  out  32  current LO register
- dataRead  out  32  combinational: `hi` when operation=MFHI, `lo` when MFLO, else 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; counter 0.
  - busy=0, done=0, hi=0, lo=0; pending result regs 0.
  - Asserting reset mid-operation discards the op, and HI/LO return to 0.
- States:
  - IDLE: no op in flight.
  - RUN: counter counts down toward commit.
- IDLE with start=1:
  - MULT/MULTU: compute the 64-bit product (signed or unsigned) at the accepting edge into pendHi/pendLo. Load counter with MUL_CYCLES-1, go to RUN, busy<=1.
  - DIV/DIVU: compute quotient into pendLo and remainder into pendHi (signed: quotient truncates toward zero, remainder takes the dividend's sign). Load counter with DIV_CYCLES-1, go to RUN, busy<=1.
  - Divide by zero: pendHi=operand1, pendLo=32'hFFFFFFFF (both DIV and DIVU).
  - Signed overflow (0x80000000 / 0xFFFFFFFF): pendLo=0x80000000, pendHi=0.
  - MTHI / MTLO: write hi / lo at that edge. Stay IDLE, busy stays 0, done stays 0.
  - MFHI, MFLO, NONE, reserved codes: no state change.
- RUN:
  - counter!=0: decrement.
  - counter==0: at that edge hi<=pendHi, lo<=pendLo, busy<=0, done<=1 for exactly one cycle, return to IDLE.
  - busy is therefore high for exactly MUL_CYCLES or DIV_CYCLES cycles after the accepting edge.
  - `start` in RUN is ignored entirely, MTHI/MTLO included; EX guarantees stall, and the bench asserts no state corruption.
- cancel:
  - In RUN: return to IDLE at the next edge, busy<=0, done stays 0, HI/LO unchanged.
  - Same cycle as the commit edge: cancel wins and no commit occurs.
  - In IDLE: any `start` in the same cycle is suppressed (no write, no op launch).
- Back-to-back: start may be accepted in the cycle done=1, since the state is already IDLE. The new op reads the just-committed HI/LO via `dataRead` if it is MFHI/MFLO.
- Reads:
  - `dataRead` while busy=1 returns the stale HI/LO. EX stalls on mduUse, so this value is never consumed.
  - `hi`/`lo` ports always show architectural values, never pending ones.
- Width rules: all arithmetic is internal at 64-bit (product) or 32-bit (quotient/remainder); no saturation.

Test Plan:
- Reset, then MULT operand1=0xFFFFFFFE (-2), operand2=0x00000003 -> busy=1 for 5 cycles, done pulses once, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> hi=7, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MFHI next cycle -> no busy, dataRead=0x12345678. MTLO issued while busy -> lo unchanged after commit of the running op.
- DIV started, cancel asserted on cycle 4, then again on the exact commit cycle of a second DIV -> busy drops next edge, done never pulses, hi/lo hold prior values.
- reset driven low mid-MULT (cycle 2) -> busy, done, hi, lo all 0 immediately, without waiting for a clock edge; start accepted normally after release.
